mp8_run_checker: RTL and testbench
==================================

Name: mp8_run_checker

Overview:
- Synthesizable run monitor for the MP-8 family. It replaces the hand-coded single-write check with a parametrised, multi-checkpoint checker.
- Watches the processor memory-write bus. Compares writes against a table of expected (address, data) checkpoints.
- Declares PASS when the halt address is fetched with all enabled checkpoints satisfied. Otherwise declares FAIL with a reason code.
- Sits beside `top`; usable in simulation benches and on FPGA, where it drives status LEDs.

Parameters:
- DATA_W, 8, data bus width.
- ADDR_W, 5, address bus width.
- NUM_CHK, 4, number of checkpoints (1..16).
- HALT_ADDR, 16, address whose appearance on addr ends the run.
- TIMEOUT, 1024, RUN cycles before timeout failure (≥2).
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; run enable.
- addr  in  ADDR_W  processor address bus.
- wdata  in  DATA_W  processor write data (AccOut).
- MemWrite  in  1  memory write strobe.
- chk_addr  in  NUM_CHK*ADDR_W  checkpoint addresses; entry i at [i*ADDR_W +: ADDR_W].
- chk_data  in  NUM_CHK*DATA_W  expected data per checkpoint.
- chk_en  in  NUM_CHK  checkpoint enables.
- busy  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- fail_code  out  2  0 none, 1 mismatch, 2 missing, 3 timeout.
- fail_idx  out  4  checkpoint index of the mismatch (valid when fail_code=1).
- fail_data  out  DATA_W  offending wdata (valid when fail_code=1).
- hit_mask  out  NUM_CHK  checkpoints satisfied so far.
- cycle_count  out  CNT_W  cycles spent in RUN; saturates at the maximum.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0.
- The table inputs must be stable while busy. The checker samples them live, with no internal copy.
- IDLE: counters held at 0. Transition to RUN when start=1; on entry, clear hit_mask, cycle_count and fail fields.
- RUN, evaluated every clock in this priority order:
  1. Write check. If MemWrite=1, compare addr against every enabled entry.
     - A matching entry with wdata==chk_data sets its hit bit.
     - A matching entry with wdata!=chk_data sends the block to FAIL with code 1. fail_idx is the lowest mismatching index; fail_data is wdata.
     - If several entries match, all are evaluated in the same cycle. Any mismatch wins over hits.
  2. Halt check. If addr==HALT_ADDR, evaluate after the write check of the same cycle, so a write on that cycle counts. Go to PASS if (hit_mask_next & chk_en)==chk_en; otherwise go to FAIL with code 2.
  3. Timeout. The timer counts RUN cycles. When the count reaches TIMEOUT-1 with no other transition, go to FAIL with code 3.
  4. Start drop. start=0 in RUN aborts to IDLE; outputs clear to 0.
- Latency: outputs are registered. done/pass rise exactly 1 cycle after the deciding bus cycle.
- cycle_count increments once per RUN cycle, including the deciding cycle. It freezes in PASS/FAIL and saturates at 2^CNT_W-1.
- Unmatched writes are ignored. Writes to HALT_ADDR are treated as a halt.
- All checkpoints disabled: the first halt gives PASS.
- PASS/FAIL are terminal while start=1, and all status is held. start=0 returns the block to IDLE next cycle; status clears on the next RUN entry, not on IDLE entry.
- Reset asserted mid-RUN or in a terminal state: immediate return to IDLE, all outputs 0.

Decomposition:
- Shared package mp8_chk_pkg holds:
  - state encoding IDLE=0, RUN=1, PASS=2, FAIL=3;
  - fail codes FC_NONE/FC_MISMATCH/FC_MISSING/FC_TIMEOUT;
  - localparam helper for index width.
- One sub-module, mp8_run_timer: the saturating cycle counter plus timeout compare, with clear/enable inputs and a timeout output.
- Checkpoint compare is a generate loop inside the top module.

Test Plan:
- Checkpoint (30, 15) enabled. MP-8 program with inFromOutside=5 writes 15 to 30, then reaches addr 16 → pass=1, fail_code=0, hit_mask=0001, done one cycle after the addr=16 cycle.
- Same setup, but the write of 14 to 30 is forced → FAIL, fail_code=1, fail_idx=0, fail_data=14; pass stays 0.
- Two checkpoints enabled, (30, 15) and (29, 5). Only addr 30 is written before the halt → FAIL code 2, hit_mask=0001.
- Processor stalled (addr never 16), TIMEOUT=64 → FAIL code 3, with done rising one cycle after cycle_count reaches 63 (its final value 64).
- MemWrite of a correct value to HALT_ADDR=16 configured as a checkpoint, on the same cycle as the halt → PASS.
- reset=0 pulse mid-RUN → all outputs 0 asynchronously. After release with start=1 → RUN again with cleared hit_mask.

Source files
------------

// File: rtl/mp8_chk_pkg.sv
// Shared types and constants for the MP-8 run checker.
package mp8_chk_pkg;

  // Checker state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } run_state_e;

  // Reason reported on fail_code.
  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_MISSING  = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fail_code_e;

  // Up to 16 checkpoints, so the reported index fits in 4 bits.
  localparam int MAX_CHK = 16;
  localparam int IDX_W   = $clog2(MAX_CHK);

endpackage

// File: rtl/mp8_run_timer.sv
// Saturating RUN-cycle counter with a timeout flag for the MP-8 run checker.
module mp8_run_timer #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  // A timeout beyond the counter range can never be reached.
  localparam bit TO_REACHABLE = (longint'(TIMEOUT) - 1) < (longint'(1) << CNT_W);

  // Count RUN cycles; clear has priority, the count sticks at its maximum.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // The current RUN cycle is the last one allowed.
  assign timeout = TO_REACHABLE && (count == TO_LAST);

endmodule

// File: rtl/mp8_run_checker.sv
// Multi-checkpoint run monitor for the MP-8 memory-write bus.
module mp8_run_checker
  import mp8_chk_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int NUM_CHK   = 4,
  parameter int HALT_ADDR = 16,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      MemWrite,
  input  logic [NUM_CHK*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHK*DATA_W-1:0] chk_data,
  input  logic [NUM_CHK-1:0]        chk_en,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [1:0]                fail_code,
  output logic [3:0]                fail_idx,
  output logic [DATA_W-1:0]         fail_data,
  output logic [NUM_CHK-1:0]        hit_mask,
  output logic [CNT_W-1:0]          cycle_count
);

  localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(HALT_ADDR);

  run_state_e         state;
  logic [NUM_CHK-1:0] wrHit;
  logic [NUM_CHK-1:0] wrMiss;
  logic [NUM_CHK-1:0] hitNext;
  logic [IDX_W-1:0]   missIdx;
  logic               anyMiss;
  logic               isHalt;
  logic               allHit;
  logic               timeout;
  logic               runEntry;
  logic               runAbort;
  logic               timerClear;
  logic               timerEnable;

  // Per-checkpoint compare of the current bus write against the table.
  for (genvar g = 0; g < NUM_CHK; g++) begin : g_chk
    logic addrEq;
    logic dataEq;
    assign addrEq    = MemWrite && chk_en[g] && (addr == chk_addr[g*ADDR_W +: ADDR_W]);
    assign dataEq    = (wdata == chk_data[g*DATA_W +: DATA_W]);
    assign wrHit[g]  = addrEq && dataEq;
    assign wrMiss[g] = addrEq && !dataEq;
  end

  // Pick the lowest-numbered mismatching checkpoint.
  always_comb begin
    // NOTE: a default before the loop keeps this purely combinational (no latch).
    missIdx = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (wrMiss[i]) missIdx = IDX_W'(i);
    end
  end

  assign anyMiss  = |wrMiss;
  assign hitNext  = hit_mask | wrHit;
  assign isHalt   = (addr == HALT_A);
  assign allHit   = ((hitNext & chk_en) == chk_en);

  assign runEntry    = (state == ST_IDLE) && start;
  assign runAbort    = (state == ST_RUN) && !anyMiss && !isHalt && !timeout && !start;
  assign timerClear  = runEntry || runAbort;
  assign timerEnable = (state == ST_RUN);

  mp8_run_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timerClear),
    .enable  (timerEnable),
    .count   (cycle_count),
    .timeout (timeout)
  );

  // Run FSM with registered status: write check, then halt, timeout, start drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_idx  <= '0;
      fail_data <= '0;
      hit_mask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            fail_data <= '0;
            hit_mask  <= '0;
          end
        end

        ST_RUN: begin
          hit_mask <= hitNext;
          if (anyMiss) begin
            state     <= ST_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= FC_MISMATCH;
            fail_idx  <= 4'(missIdx);
            fail_data <= wdata;
          end else if (isHalt) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (allHit) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end else begin
              state     <= ST_FAIL;
              fail_code <= FC_MISSING;
            end
          end else if (timeout) begin
            state     <= ST_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= FC_TIMEOUT;
          end else if (!start) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            fail_data <= '0;
            hit_mask  <= '0;
          end
        end

        ST_PASS, ST_FAIL: begin
          // Status is held until the next RUN entry; only done/pass drop here.
          if (!start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp8_run_checker.sv
// Self-checking bench for mp8_run_checker: directed scenarios plus randomized
// bus traffic compared against a behavioural model every cycle.
module tb_mp8_run_checker;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 5;
  localparam int NUM_CHK   = 4;
  localparam int HALT_ADDR = 16;
  localparam int TIMEOUT   = 64;
  localparam int CNT_W     = 16;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      start = 1'b0;
  logic [ADDR_W-1:0]         addr = '0;
  logic [DATA_W-1:0]         wdata = '0;
  logic                      MemWrite = 1'b0;
  logic [NUM_CHK*ADDR_W-1:0] chk_addr = '0;
  logic [NUM_CHK*DATA_W-1:0] chk_data = '0;
  logic [NUM_CHK-1:0]        chk_en = '0;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic [1:0]                fail_code;
  logic [3:0]                fail_idx;
  logic [DATA_W-1:0]         fail_data;
  logic [NUM_CHK-1:0]        hit_mask;
  logic [CNT_W-1:0]          cycle_count;

  mp8_run_checker #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_CHK   (NUM_CHK),
    .HALT_ADDR (HALT_ADDR),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .addr        (addr),
    .wdata       (wdata),
    .MemWrite    (MemWrite),
    .chk_addr    (chk_addr),
    .chk_data    (chk_data),
    .chk_en      (chk_en),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .fail_idx    (fail_idx),
    .fail_data   (fail_data),
    .hit_mask    (hit_mask),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: phase of the run plus the status it should report.
  typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL} mphase_e;
  mphase_e            m_phase;
  logic [NUM_CHK-1:0] m_hits;
  int                 m_cnt;
  int                 m_code;
  int                 m_idx;
  int                 m_data;

  function automatic int tbl_addr(input int i);
    return int'(chk_addr[i*ADDR_W +: ADDR_W]);
  endfunction

  function automatic int tbl_data(input int i);
    return int'(chk_data[i*DATA_W +: DATA_W]);
  endfunction

  task automatic model_clear();
    m_phase = M_IDLE;
    m_hits  = '0;
    m_cnt   = 0;
    m_code  = 0;
    m_idx   = 0;
    m_data  = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit                 mis;
    int                 first;
    logic [NUM_CHK-1:0] new_hits;
    bit                 last_cycle;
    if (!reset) begin
      model_clear();
      return;
    end
    case (m_phase)
      M_IDLE: if (start) begin
        model_clear();
        m_phase = M_RUN;
      end
      M_RUN: begin
        mis = 0;
        first = 0;
        new_hits = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
          if (chk_en[i] && MemWrite && int'(addr) == tbl_addr(i)) begin
            if (int'(wdata) == tbl_data(i)) new_hits[i] = 1'b1;
            else if (!mis) begin
              mis = 1;
              first = i;
            end
          end
        end
        last_cycle = (m_cnt == TIMEOUT - 1);
        m_hits = m_hits | new_hits;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (mis) begin
          m_phase = M_FAIL;
          m_code  = 1;
          m_idx   = first;
          m_data  = int'(wdata);
        end else if (int'(addr) == HALT_ADDR) begin
          if ((m_hits & chk_en) == chk_en) m_phase = M_PASS;
          else begin
            m_phase = M_FAIL;
            m_code  = 2;
          end
        end else if (last_cycle) begin
          m_phase = M_FAIL;
          m_code  = 3;
        end else if (!start) begin
          model_clear();
        end
      end
      default: if (!start) m_phase = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check("busy", busy, m_phase == M_RUN);
    check("done", done, m_phase == M_PASS || m_phase == M_FAIL);
    check("pass", pass, m_phase == M_PASS);
    check("fail_code", fail_code, m_code);
    check("hit_mask", hit_mask, m_hits);
    check("cycle_count", cycle_count, m_cnt);
    if (m_code == 1) begin
      check("fail_idx", fail_idx, m_idx);
      check("fail_data", fail_data, m_data);
    end
  endtask

  // One clock: model sees the edge inputs, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic bus(input int a, input bit we, input int d);
    addr     = ADDR_W'(a);
    MemWrite = we;
    wdata    = DATA_W'(d);
    tick();
  endtask

  task automatic set_chk(input int i, input int a, input int d);
    chk_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    chk_data[i*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic end_run();
    start = 1'b0;
    bus(0, 0, 0);
  endtask

  initial begin
    int sel;
    int halt_pct;
    model_clear();

    // Reset state.
    bus(0, 0, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", cycle_count, 0);
    reset = 1'b1;
    bus(0, 0, 0);

    // Single checkpoint (30,15) written correctly, then halt.
    set_chk(0, 30, 15);
    chk_en = 4'b0001;
    start = 1'b1;
    bus(0, 0, 0);
    check("t1_entry_busy", busy, 1);
    bus(1, 0, 0);
    bus(2, 0, 0);
    bus(30, 1, 15);
    bus(3, 0, 0);
    check("t1_pre_halt_done", done, 0);
    bus(16, 0, 0);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_code", fail_code, 0);
    check("t1_hits", hit_mask, 4'b0001);
    check("t1_count", cycle_count, 5);
    bus(5, 0, 0);
    check("t1_hold_pass", pass, 1);
    start = 1'b0;
    bus(0, 0, 0);
    check("t1_idle_done", done, 0);
    check("t1_idle_hits_held", hit_mask, 4'b0001);
    start = 1'b1;
    bus(0, 0, 0);
    check("t1_reentry_hits", hit_mask, 0);

    // Wrong data to the checkpoint.
    bus(30, 1, 14);
    check("t2_code", fail_code, 1);
    check("t2_idx", fail_idx, 0);
    check("t2_data", fail_data, 14);
    check("t2_pass", pass, 0);
    end_run();

    // Two checkpoints, only one written before halt.
    set_chk(1, 29, 5);
    chk_en = 4'b0011;
    start = 1'b1;
    bus(0, 0, 0);
    bus(30, 1, 15);
    bus(16, 0, 0);
    check("t3_code", fail_code, 2);
    check("t3_hits", hit_mask, 4'b0001);
    check("t3_pass", pass, 0);
    end_run();

    // Stalled processor runs into the timeout.
    chk_en = 4'b0001;
    start = 1'b1;
    bus(0, 0, 0);
    for (int k = 1; k <= TIMEOUT - 1; k++) bus(3, 0, 0);
    check("t4_count_last", cycle_count, TIMEOUT - 1);
    check("t4_not_done", done, 0);
    bus(3, 0, 0);
    check("t4_done", done, 1);
    check("t4_code", fail_code, 3);
    check("t4_count_final", cycle_count, TIMEOUT);
    end_run();

    // Checkpoint on the halt address written on the halt cycle.
    set_chk(0, 16, 9);
    chk_en = 4'b0001;
    start = 1'b1;
    bus(0, 0, 0);
    bus(16, 1, 9);
    check("t5_pass", pass, 1);
    check("t5_hits", hit_mask, 4'b0001);
    end_run();

    // Asynchronous reset mid-run, then re-entry and a start-drop abort.
    set_chk(0, 30, 15);
    start = 1'b1;
    bus(0, 0, 0);
    bus(30, 1, 15);
    check("t6_hit_before_rst", hit_mask, 4'b0001);
    bus(2, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_hits", hit_mask, 0);
    check("t6_rst_count", cycle_count, 0);
    model_clear();
    #1 reset = 1'b1;
    bus(2, 0, 0);
    check("t6_rerun_busy", busy, 1);
    check("t6_rerun_hits", hit_mask, 0);
    bus(30, 1, 15);
    start = 1'b0;
    bus(1, 0, 0);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_hits", hit_mask, 0);
    check("t6_abort_count", cycle_count, 0);

    // Randomized runs against the model.
    for (int r = 0; r < 40; r++) begin
      start = 1'b0;
      for (int i = 0; i < NUM_CHK; i++) begin
        sel = int'($urandom_range(0, 3));
        set_chk(i, (sel == 0) ? int'($urandom_range(0, 31)) : 20 + int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 5) == 0) set_chk(int'($urandom_range(0, NUM_CHK - 1)), HALT_ADDR, 2);
      chk_en = NUM_CHK'($urandom);
      halt_pct = (r % 4 == 0) ? 0 : 8;
      bus(0, 0, 0);
      start = 1'b1;
      bus(0, 0, 0);
      for (int c = 0; c < 100 && m_phase == M_RUN; c++) begin
        sel = int'($urandom_range(0, 99));
        if (sel < halt_pct) addr = ADDR_W'(HALT_ADDR);
        else if (sel < 70) addr = ADDR_W'(tbl_addr(int'($urandom_range(0, NUM_CHK - 1))));
        else addr = ADDR_W'($urandom_range(0, 31));
        MemWrite = $urandom_range(0, 1) == 1;
        wdata = DATA_W'($urandom_range(0, 3));
        for (int i = 0; i < NUM_CHK; i++)
          if (int'(addr) == tbl_addr(i) && $urandom_range(0, 9) < 7) wdata = DATA_W'(tbl_data(i));
        if ($urandom_range(0, 59) == 0) start = 1'b0;
        tick();
      end
      check("rand_run_ended", m_phase != M_RUN, 1);
      bus(0, 0, 0);
      start = 1'b0;
      bus(0, 0, 0);
      bus(0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
